// File: rtl/adder_bist.sv
// Built-in self-test for an external adder. Drives a fixed-then-pseudorandom
// vector stream into the adder under test, carries the expected result down a
// delay line that matches the adder latency, and counts/captures mismatches.
//
// Handshake: start is a single-cycle request with no ready; it is accepted only
// in IDLE or DONE and silently dropped in RUN/DRAIN. busy/done/pass are level
// status outputs derived from the FSM state.
module adder_bist #(
  parameter int          WIDTH   = 8,
  parameter int          DUT_LAT = 0,
  parameter int          NUM_VEC = 256,
  parameter logic [31:0] SEED    = 32'h0000_0008
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop_on_err,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_ci,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_co,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      fail_idx,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_ci,
  output logic [WIDTH:0]   fail_got,
  output logic [WIDTH:0]   fail_exp,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [31:0] TAPS       = 32'h8020_0003;
  localparam logic [15:0] LAST_IDX   = 16'(NUM_VEC - 1);
  localparam logic [2:0]  DRAIN_LAST = 3'((DUT_LAT > 0) ? DUT_LAT - 1 : 0);

  // One in-flight vector: what was sent and what must come back.
  typedef struct packed {
    logic             valid;
    logic [15:0]      idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH:0]   exp;
  } slot_t;

  state_t      state, state_nxt;
  slot_t       pipe [0:DUT_LAT];
  slot_t       issue_slot, cmp;
  logic [15:0] vec_idx, nxt_idx;
  logic [2:0]  drain_cnt;
  logic        stop_mode;
  logic [31:0] lfsr;

  logic             launch, last_issue, issue, mismatch, abort, drain_end;
  logic [WIDTH-1:0] nxt_a, nxt_b;
  logic             nxt_ci;
  logic [WIDTH:0]   got;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
  endfunction

  // Issue decision, next vector selection and the compare at the delay-line tail.
  always_comb begin
    launch     = start && (state == IDLE || state == DONE);
    last_issue = (state == RUN) && (vec_idx == LAST_IDX);
    cmp        = pipe[DUT_LAT];
    got        = {dut_co, dut_sum};
    mismatch   = cmp.valid && (got != cmp.exp);
    abort      = mismatch && stop_mode;
    issue      = launch || ((state == RUN) && !last_issue && !abort);
    drain_end  = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
    nxt_idx    = launch ? 16'd0 : vec_idx + 16'd1;
    // Vector 0 is all zeros, vector 1 ripples a carry through every bit.
    if (nxt_idx == 16'd0) begin
      nxt_a  = '0;
      nxt_b  = '0;
      nxt_ci = 1'b0;
    end else if (nxt_idx == 16'd1) begin
      nxt_a  = '1;
      nxt_b  = '0;
      nxt_ci = 1'b1;
    end else begin
      nxt_a  = lfsr[WIDTH-1:0];
      nxt_b  = lfsr[31:32-WIDTH];
      nxt_ci = lfsr[16];
    end
    issue_slot.valid = 1'b1;
    issue_slot.idx   = nxt_idx;
    issue_slot.a     = nxt_a;
    issue_slot.b     = nxt_b;
    issue_slot.ci    = nxt_ci;
    issue_slot.exp   = {1'b0, nxt_a} + {1'b0, nxt_b} + {{WIDTH{1'b0}}, nxt_ci};
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN: begin
        if (abort)           state_nxt = DONE;
        else if (last_issue) state_nxt = (DUT_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN:   if (abort || drain_end) state_nxt = DONE;
      DONE:    if (launch) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Vector generator: index, LFSR and the registered operands to the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx   <= '0;
      drain_cnt <= '0;
      stop_mode <= 1'b0;
      lfsr      <= SEED;
      dut_a     <= '0;
      dut_b     <= '0;
      dut_ci    <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      if (launch) stop_mode <= stop_on_err;
      if (launch)                             lfsr <= SEED;
      else if (issue && (nxt_idx >= 16'd2))   lfsr <= lfsr_step(lfsr);
      if (issue) begin
        vec_idx <= nxt_idx;
        dut_a   <= nxt_a;
        dut_b   <= nxt_b;
        dut_ci  <= nxt_ci;
      end
    end
  end

  // Expected-result delay line; an abort discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DUT_LAT; j++) pipe[j] <= '0;
    end else begin
      pipe[0] <= issue ? issue_slot : '0;
      for (int j = 1; j <= DUT_LAT; j++) pipe[j] <= abort ? '0 : pipe[j-1];
    end
  end

  // Error counter (saturating) and first-failure capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_ci   <= 1'b0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else if (launch) begin
      err_count <= '0;
      fail_idx  <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_ci   <= 1'b0;
      fail_got  <= '0;
      fail_exp  <= '0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (err_count == 16'd0) begin
        fail_idx <= cmp.idx;
        fail_a   <= cmp.a;
        fail_b   <= cmp.b;
        fail_ci  <= cmp.ci;
        fail_got <= got;
        fail_exp <= cmp.exp;
      end
    end
  end

  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = (state == DONE) && (err_count == 16'd0);
  assign dbg_state = state;

endmodule
